mips_mul: RTL and testbench

//   Multicycle signed/unsigned multiplier for MULT/MULTU; the multiply-side

---
 rtl/mips_mul.sv | 110 +++++++++++
 tb/tb_mips_mul.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mips_mul.sv
// Multicycle MULT/MULTU unit: shift-add over operand magnitudes, BITS_PER_CYCLE
// multiplier bits per clock, sign-corrected 2*WIDTH product written to hi/lo.
module mips_mul #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int AW = PW + BITS_PER_CYCLE;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [PW-1:0]    a_sh_q;
  logic [WIDTH-1:0] b_q;
  logic [AW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             busy_q, ready_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0] a_mag_d, b_mag_d;
  logic [AW-1:0]    pp_d;
  logic [PW-1:0]    prod_d, res_d;

  // Most negative operand negates to itself, which reads correctly as 2^(WIDTH-1).
  always_comb begin
    a_mag_d = (signed_op & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag_d = (signed_op & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  // Partial product for the current multiplier slice; a_sh_q already carries the slice weight.
  always_comb begin
    pp_d = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_q[j]) pp_d = pp_d + (AW'(a_sh_q) << j);
    end
  end

  always_comb begin
    prod_d = acc_q[PW-1:0];
    res_d  = neg_q ? (~prod_d + PW'(1)) : prod_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          ready_q <= 1'b0;
          if (start) begin
            a_sh_q  <= PW'(a_mag_d);
            b_q     <= b_mag_d;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q  <= acc_q + pp_d;
          a_sh_q <= a_sh_q << BITS_PER_CYCLE;
          b_q    <= b_q >> BITS_PER_CYCLE;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= res_d[PW-1:WIDTH];
          lo_q    <= res_d[WIDTH-1:0];
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mips_mul.sv
// Scoreboarded bench for mips_mul: expected products queued at launch, popped on ready.
module tb_mips_mul;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_op = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, ready;
  logic [31:0] hi, lo;

  int checks = 0, fails = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];

  mips_mul #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .busy(busy), .ready(ready), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic [63:0] ux, uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (s) return sx * sy;
    return ux * uy;
  endfunction

  // Drive start at a falling edge, return the cycle stamp of the sampling edge.
  task automatic launch(input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic push, input logic keep, output int t0);
    @(negedge clk);
    signed_op = s; a = x; b = y; start = 1'b1;
    if (push) exp_q.push_back(model(s, x, y));
    @(posedge clk);
    #1;
    t0 = cyc;
    start = keep;
  endtask

  task automatic wait_ready(input int t0, input int lat, input string nm);
    logic [63:0] e;
    bit seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: ready timeout, got none, required latency %0d", nm, lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (cyc - t0 !== lat) begin
      fails++;
      $display("FAIL %s latency: got %0d required %0d", nm, cyc - t0, lat);
    end
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: ready with empty scoreboard", nm);
      return;
    end
    e = exp_q.pop_front();
    if ({hi, lo} !== e) begin
      fails++;
      $display("FAIL %s result: got %h_%h required %h_%h", nm, hi, lo, e[63:32], e[31:0]);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy at ready: got %b required 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy  !== 1'b0) begin fails++; $display("FAIL reset busy: got %b required 0", busy); end
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL reset ready: got %b required 0", ready); end
    checks++; if (hi !== 32'h0) begin fails++; $display("FAIL reset hi: got %h required 0", hi); end
    checks++; if (lo !== 32'h0) begin fails++; $display("FAIL reset lo: got %h required 0", lo); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int t0;
    launch(1'b0, 32'd3, 32'd5, 1'b1, 1'b0, t0);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic busy in run: got %b required 1", busy); end
    wait_ready(t0, 17, "multu_3x5");
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL basic ready pulse width: got %b required 0", ready); end
    repeat (3) @(negedge clk);
    checks++; if ({hi, lo} !== 64'hF) begin fails++; $display("FAIL basic hold: got %h_%h required 0_f", hi, lo); end
  endtask

  task automatic test_signed();
    int t0;
    launch(1'b1, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, t0);
    wait_ready(t0, 17, "mult_m3x5");
    launch(1'b0, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, t0);
    wait_ready(t0, 17, "multu_fffffffdx5");
  endtask

  task automatic test_boundary();
    int t0;
    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, t0);
    wait_ready(t0, 17, "multu_max");
    launch(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, t0);
    wait_ready(t0, 17, "mult_minxmin");
    launch(1'b1, 32'h0, 32'h8000_0000, 1'b1, 1'b0, t0);
    wait_ready(t0, 17, "mult_zero");
    for (int i = 0; i < 6; i++) begin
      launch(1'(i % 2), $urandom, $urandom, 1'b1, 1'b0, t0);
      wait_ready(t0, 17, "random");
    end
  endtask

  task automatic test_ignore_start();
    int t0, extra;
    launch(1'b0, 32'h1234_5678, 32'h0000_9ABC, 1'b1, 1'b0, t0);
    repeat (5) @(negedge clk);
    a = 32'd7; b = 32'd7; signed_op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(t0, 17, "ignore_busy_start");
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ready) extra++;
    end
    checks++; if (extra !== 0) begin fails++; $display("FAIL ignore extra ready pulses: got %0d required 0", extra); end
  endtask

  task automatic test_back_to_back();
    int t0;
    launch(1'b0, 32'd10, 32'd11, 1'b1, 1'b1, t0);
    a = 32'd2; b = 32'd9;
    exp_q.push_back(model(1'b0, 32'd2, 32'd9));
    wait_ready(t0, 17, "b2b_first");
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++; if ({busy, ready} !== 2'b10) begin fails++; $display("FAIL b2b restart busy/ready: got %b required 10", {busy, ready}); end
    wait_ready(t0, 35, "b2b_second");
  endtask

  task automatic test_reset_mid();
    int t0, extra;
    launch(1'b0, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0, 1'b0, t0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, ready} !== 2'b00) begin fails++; $display("FAIL midreset busy/ready: got %b required 00", {busy, ready}); end
    checks++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL midreset hilo: got %h_%h required 0_0", hi, lo); end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ready || busy) extra++;
    end
    checks++; if (extra !== 0) begin fails++; $display("FAIL midreset activity cycles: got %0d required 0", extra); end
    checks++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL midreset hold: got %h_%h required 0_0", hi, lo); end
    launch(1'b0, 32'd6, 32'd7, 1'b1, 1'b0, t0);
    wait_ready(t0, 17, "after_reset_6x7");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_boundary();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard leftover: got %0d entries required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
